data_memory_ws: RTL and testbench

- Parametrised successor to the pipelined CPU's single-cycle data memory: byte-addressable, little-endian data memory with a configurable wait-state count.
- Supports byte/halfword/word access with signed or unsigned load extension, a BUSYWAIT stall handshake, and an ERROR flag for misaligned, out-of-range or illegal requests.
- Sits between cpu_pipeline's MEM stage and the backing array; the CPU freezes its pipeline while BUSYWAIT is high.

---
 rtl/data_memory_ws.sv | 180 ++++++++++++++++++
 tb/tb_data_memory_ws.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ws
// Brief    : Byte-addressable little-endian data memory with a configurable
//            number of wait states, BUSYWAIT stall handshake and ERROR pulse.
// Revision : 1.0  initial release
// ============================================================================
module data_memory_ws #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int LATENCY     = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ_EN,
  input  logic                  WRITE_EN,
  input  logic [1:0]            SIZE,
  input  logic                  SIGNED,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITEDATA,
  output logic [31:0]           READDATA,
  output logic                  BUSYWAIT,
  output logic                  ERROR
);

  localparam int c_IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] c_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;

  // Request captured in IDLE; live inputs are ignored after that
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  rd_q;
  logic                  wr_q;

  logic [7:0]  mem_q [DEPTH_BYTES];
  logic [31:0] rdata_q;
  logic        error_q;

  logic                  w_req;
  logic                  w_capture;
  logic                  w_access;
  logic                  w_fault;
  logic [ADDR_WIDTH:0]   w_span;
  logic [ADDR_WIDTH:0]   w_last;
  logic [c_IDX_W-1:0]    w_lane [4];
  logic [7:0]            w_byte [4];
  logic [31:0]           w_load;

  assign w_req     = READ_EN | WRITE_EN;
  assign w_capture = (state_q == S_IDLE) && w_req;
  // The access happens on the edge that ends the last BUSY cycle
  assign w_access  = (state_q == S_BUSY) && (cnt_q == '0);

  // State and wait-state counter register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and BUSYWAIT decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    BUSYWAIT = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          BUSYWAIT = 1'b1;
          state_d  = S_BUSY;
          cnt_d    = c_CNT_LOAD;
        end
      end
      S_BUSY: begin
        BUSYWAIT = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - c_CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else if (w_capture) begin
      addr_q   <= ADDRESS;
      wdata_q  <= WRITEDATA;
      size_q   <= SIZE;
      signed_q <= SIGNED;
      rd_q     <= READ_EN;
      wr_q     <= WRITE_EN;
    end
  end

  // Fault detection and little-endian byte lanes for the captured request
  always_comb begin
    case (size_q)
      2'b01:   w_span = (ADDR_WIDTH + 1)'(1);
      2'b10:   w_span = (ADDR_WIDTH + 1)'(3);
      default: w_span = '0;
    endcase
    // One extra bit so the last byte address cannot wrap past the top
    w_last  = {1'b0, addr_q} + w_span;
    w_fault = (rd_q & wr_q)
            | (size_q == 2'b11)
            | ((size_q == 2'b01) & addr_q[0])
            | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
            | (w_last >= c_DEPTH);
    for (int k = 0; k < 4; k++) begin
      w_lane[k] = addr_q[c_IDX_W-1:0] + c_IDX_W'(k);
      w_byte[k] = mem_q[w_lane[k]];
    end
    case (size_q)
      2'b00:   w_load = {{24{signed_q & w_byte[0][7]}}, w_byte[0]};
      2'b01:   w_load = {{16{signed_q & w_byte[1][7]}}, w_byte[1], w_byte[0]};
      default: w_load = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
    endcase
  end

  // Backing array: cleared on reset, written only by a fault-free store
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (w_access && !w_fault && wr_q) begin
      mem_q[w_lane[0]] <= wdata_q[7:0];
      if (size_q != 2'b00) mem_q[w_lane[1]] <= wdata_q[15:8];
      if (size_q == 2'b10) begin
        mem_q[w_lane[2]] <= wdata_q[23:16];
        mem_q[w_lane[3]] <= wdata_q[31:24];
      end
    end
  end

  // Registered load result and ERROR pulse, valid during DONE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (w_access) begin
      if (w_fault) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end else if (rd_q) begin
        rdata_q <= w_load;
      end
    end else if (state_q == S_DONE) begin
      error_q <= 1'b0;
    end
  end

  assign READDATA = rdata_q;
  assign ERROR    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ws
// Brief    : Self-checking bench for data_memory_ws (LATENCY 2 and 1
//            instances) against a byte-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_memory_ws;

  localparam int c_DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        re0, we0, re1, we1;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1;
  logic        bw0, bw1, err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one byte array and last READDATA per instance
  logic [7:0]  mem_m [2][c_DEPTH];
  logic [31:0] rd_m  [2];

  always #5 CLK = ~CLK;

  data_memory_ws #(.DEPTH_BYTES(c_DEPTH), .ADDR_WIDTH(32), .LATENCY(2)) dut (
    .CLK(CLK), .RESET(RESET), .READ_EN(re0), .WRITE_EN(we0), .SIZE(size),
    .SIGNED(sgn), .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata0),
    .BUSYWAIT(bw0), .ERROR(err0)
  );

  data_memory_ws #(.DEPTH_BYTES(c_DEPTH), .ADDR_WIDTH(32), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .READ_EN(re1), .WRITE_EN(we1), .SIZE(size),
    .SIGNED(sgn), .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata1),
    .BUSYWAIT(bw1), .ERROR(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      rd_m[s] = 32'd0;
      for (int i = 0; i < c_DEPTH; i++) mem_m[s][i] = 8'h00;
    end
  endtask

  // One complete access on instance sel; called right after a rising edge
  // with the DUT in IDLE, returns #1 after the edge that ends DONE.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold);
    int          busy;
    int          lat;
    int          n;
    logic        fault;
    logic [31:0] exp_rd;
    logic [63:0] end_a;
    lat   = (sel == 0) ? 2 : 1;
    n     = (sz == 2'b10) ? 4 : ((sz == 2'b01) ? 2 : 1);
    end_a = {32'd0, a} + 64'(n);
    fault = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
            (sz == 2'b10 && a[1:0] != 2'b00) || (end_a > 64'(c_DEPTH));
    if (fault) begin
      exp_rd = 32'd0;
    end else if (rd) begin
      exp_rd = 32'd0;
      for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(mem_m[sel][a + 32'(i)]) << (8 * i));
      if (sg && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * n));
    end else begin
      for (int i = 0; i < n; i++) mem_m[sel][a + 32'(i)] = wd[8*i +: 8];
      exp_rd = rd_m[sel];
    end
    rd_m[sel] = exp_rd;

    addr = a; wdata = wd; size = sz; sgn = sg;
    if (sel == 0) begin re0 = rd; we0 = wr; end
    else          begin re1 = rd; we1 = wr; end

    busy = 0;
    @(negedge CLK);
    while (((sel == 0) ? bw0 : bw1) && busy < 20) begin
      busy++;
      @(negedge CLK);
    end
    check("busy cycles", 32'(busy), 32'(lat + 1));
    check("error in done", 32'((sel == 0) ? err0 : err1), 32'(fault));
    check("readdata in done", (sel == 0) ? rdata0 : rdata1, exp_rd);
    @(posedge CLK);
    #1;
    check("error cleared", 32'((sel == 0) ? err0 : err1), 32'd0);
    if (!hold) begin re0 = 0; we0 = 0; re1 = 0; we1 = 0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0]  sz;
    logic [31:0] a;
    RESET = 1; re0 = 0; we0 = 0; re1 = 0; we1 = 0;
    size = 0; sgn = 0; addr = 0; wdata = 0;
    clear_model();
    repeat (3) @(posedge CLK);
    #1 RESET = 0;
    @(negedge CLK);
    check("reset readdata", rdata0, 32'd0);
    check("reset busywait", 32'(bw0), 32'd0);
    check("reset error", 32'(err0), 32'd0);
    @(posedge CLK); #1;

    // Word store / load
    access(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
    access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    check("word load const", rdata0, 32'hDEAD_BEEF);
    // Byte / halfword loads with both extensions
    access(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, 0);
    check("lbu const", rdata0, 32'h0000_00EF);
    access(0, 1, 0, 2'b00, 1, 32'h10, 32'h0, 0);
    check("lb const", rdata0, 32'hFFFF_FFEF);
    access(0, 1, 0, 2'b01, 1, 32'h12, 32'h0, 0);
    check("lh const", rdata0, 32'hFFFF_DEAD);
    access(0, 1, 0, 2'b01, 0, 32'h12, 32'h0, 0);
    check("lhu const", rdata0, 32'h0000_DEAD);
    // Partial stores
    access(0, 0, 1, 2'b00, 0, 32'h11, 32'hAAAA_AA55, 0);
    access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    check("sb merge const", rdata0, 32'hDEAD_55EF);
    access(0, 0, 1, 2'b01, 0, 32'h12, 32'hBBBB_1234, 0);
    access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    check("sh merge const", rdata0, 32'h1234_55EF);
    // Faults
    access(0, 1, 0, 2'b10, 0, 32'h11, 32'h0, 0);
    access(0, 0, 1, 2'b01, 0, 32'h13, 32'hFFFF_FFFF, 0);
    access(0, 1, 0, 2'b10, 0, 32'(c_DEPTH - 2), 32'h0, 0);
    access(0, 1, 0, 2'b10, 0, 32'(c_DEPTH - 4), 32'h0, 0);
    access(0, 0, 1, 2'b01, 0, 32'(c_DEPTH - 1), 32'h1111_1111, 0);
    access(0, 0, 1, 2'b11, 0, 32'h10, 32'h0, 0);
    access(0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 0);
    access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    check("mem unchanged after faults", rdata0, 32'h1234_55EF);
    // Held request: second access only starts in the following IDLE
    access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 1);
    access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);

    // Reset in the second BUSY cycle of a store
    addr = 32'h20; wdata = 32'hCAFE_F00D; size = 2'b10; sgn = 0; we0 = 1;
    @(negedge CLK);
    check("mid-reset request busy", 32'(bw0), 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1; we0 = 0;
    @(posedge CLK); #1;
    RESET = 0;
    clear_model();
    @(negedge CLK);
    check("mid-reset busywait", 32'(bw0), 32'd0);
    check("mid-reset readdata", rdata0, 32'd0);
    @(posedge CLK); #1;
    access(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 0);
    check("aborted store not committed", rdata0, 32'd0);

    // LATENCY = 1 instance
    access(1, 0, 1, 2'b10, 0, 32'h40, 32'h8765_4321, 0);
    access(1, 1, 0, 2'b01, 1, 32'h42, 32'h0, 0);
    check("lat1 lh const", rdata1, 32'hFFFF_8765);
    access(1, 1, 0, 2'b10, 0, 32'h41, 32'h0, 0);

    // Randomized traffic on both instances
    for (int it = 0; it < 200; it++) begin
      r  = int'($urandom_range(0, 9));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, c_DEPTH + 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      access(int'($urandom_range(0, 1)), (r <= 5), (r == 0 || r > 5), sz,
             1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
